// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Constants and state encodings shared by the UART receiver
//                and transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Default bit period for 115200 baud from a 100 MHz clock.
  localparam int CLOCK_DIV = 868;
  localparam int HALF_DIV  = CLOCK_DIV / 2;

  // Line-protocol phases, common to both directions of the link.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync
//  Description : Two-flop synchronizer for the asynchronous serial line.
//                Both flops reset high so that reset looks like an idle line.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  // Two-stage capture of the asynchronous input; idle-high after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule : uart_sync
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver with centre-of-bit sampling, a level
//                valid/ack handshake, framing-error and overrun pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int BAUD_RATE = 115200,
  parameter int CLK_FREQ  = 100_000_000,
  parameter int CLOCK_DIV = CLK_FREQ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  import uart_pkg::*;

  // Terminal counts: end of a full bit and middle of the start bit.
  localparam logic [15:0] BIT_END  = 16'(CLOCK_DIV - 1);
  localparam logic [15:0] HALF_END = 16'(CLOCK_DIV / 2 - 1);

  uart_state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shift, shift_n;
  logic [7:0]  data_n;
  logic        valid_n, ferr_n, ovr_n;
  logic        hold_off, hold_off_n;  // set after a framing error until the line goes high
  logic        rx_s;

  uart_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (rx_serial),
    .dout (rx_s)
  );

  assign rx_busy = (state != IDLE);

  // Next-state and datapath decisions for the receive sequence.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt + 16'd1;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    data_n     = rx_data;
    valid_n    = rx_valid & ~rx_ack;
    ferr_n     = 1'b0;
    ovr_n      = 1'b0;
    hold_off_n = hold_off;
    case (state)
      IDLE: begin
        cnt_n     = 16'd0;
        bit_idx_n = 3'd0;
        if (rx_s) begin
          hold_off_n = 1'b0;
        end else if (!hold_off) begin
          state_n = START;
        end
      end
      START: begin
        if (cnt == HALF_END) begin
          cnt_n   = 16'd0;
          state_n = rx_s ? IDLE : DATA;  // high at mid-start means a glitch
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_n            = 16'd0;
          shift_n[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
            bit_idx_n = 3'd0;
            state_n   = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt == BIT_END) begin
          cnt_n   = 16'd0;
          state_n = IDLE;
          if (rx_s) begin
            // A fresh byte always wins; it is an overrun only if the old one was never taken.
            data_n  = shift;
            valid_n = 1'b1;
            ovr_n   = rx_valid & ~rx_ack;
          end else begin
            ferr_n     = 1'b1;
            hold_off_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 16'd0;
      end
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      hold_off  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      rx_data   <= data_n;
      rx_valid  <= valid_n;
      frame_err <= ferr_n;
      overrun   <= ovr_n;
      hold_off  <= hold_off_n;
    end
  end

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx: directed frames plus
//                random frames checked against a byte-level receiver model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int DIV  = 64;
  localparam int HALF = DIV / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_serial = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, overrun;

  uart_rx #(.CLOCK_DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_serial (rx_serial),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Event monitor: pulse counts and the cycle at which rx_valid rises.
  int   cyc = 0;
  int   ferr_seen = 0;
  int   ovr_seen = 0;
  int   rise_cyc = -1;
  logic prev_valid = 1'b0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (frame_err) ferr_seen++;
    if (overrun) ovr_seen++;
    if (rx_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = rx_valid;
  end

  // Reference model: what the consumer should currently see.
  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;
  int         t0 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame starting at the current negedge.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    rx_serial = 1'b0;
    t0 = cyc;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      tick(DIV);
    end
    rx_serial = stop_ok;
    tick(DIV);
    rx_serial = 1'b1;
  endtask

  task automatic ack_pulse(input string tag);
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    m_valid = 1'b0;
    tick(1);
    chk(tag, rx_valid, m_valid);
  endtask

  // One frame, then compare outputs and pulse counts against the model.
  task automatic frame_and_check(input string tag, input logic [7:0] b, input logic ok);
    int   f0, o0;
    logic exp_ovr;
    f0 = ferr_seen;
    o0 = ovr_seen;
    send_frame(b, ok);
    tick(4);
    exp_ovr = 1'b0;
    if (ok) begin
      exp_ovr = m_valid;
      m_valid = 1'b1;
      m_data  = b;
    end
    chk({tag, "_data"}, rx_data, m_data);
    chk({tag, "_valid"}, rx_valid, m_valid);
    chk({tag, "_ferr"}, ferr_seen - f0, !ok);
    chk({tag, "_ovr"}, ovr_seen - o0, exp_ovr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int f0, o0, lat, lat_exp;

    // Reset state, checked while reset is held and after release.
    tick(3);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_busy", rx_busy, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    rst = 1'b0;
    tick(4);
    chk("idle_busy", rx_busy, 1'b0);

    // 0xA5 with latency: half bit + 9 full bits + 2-cycle synchronizer.
    frame_and_check("a5", 8'hA5, 1'b1);
    lat     = rise_cyc - t0;
    lat_exp = HALF + 9 * DIV + 3;
    chk("a5_latency_ok", (lat >= lat_exp - 2 && lat <= lat_exp + 2), 1'b1);
    ack_pulse("a5_ack");
    ack_pulse("ack_when_idle");

    // Short low glitch: false start, nothing reported.
    f0 = ferr_seen;
    rx_serial = 1'b0;
    tick(DIV / 4);
    rx_serial = 1'b1;
    tick(DIV);
    chk("glitch_busy", rx_busy, 1'b0);
    chk("glitch_valid", rx_valid, 1'b0);
    chk("glitch_ferr", ferr_seen - f0, 0);

    // Bad stop bit.
    frame_and_check("bad_3c", 8'h3C, 1'b0);

    // Back-to-back 0x11, 0x22 with no ack.
    o0 = ovr_seen;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(4);
    m_data = 8'h22;
    m_valid = 1'b1;
    chk("b2b_data", rx_data, 8'h22);
    chk("b2b_valid", rx_valid, 1'b1);
    chk("b2b_ovr", ovr_seen - o0, 1);

    // Break: one framing error, then re-arm once the line is high.
    f0 = ferr_seen;
    rx_serial = 1'b0;
    tick(12 * DIV);
    rx_serial = 1'b1;
    tick(DIV);
    chk("break_ferr", ferr_seen - f0, 1);
    chk("break_data", rx_data, m_data);
    chk("break_busy", rx_busy, 1'b0);
    frame_and_check("after_break", 8'hC3, 1'b1);

    // Reset during bit 4 of 0xFF abandons the frame.
    rx_serial = 1'b0;
    tick(DIV);
    rx_serial = 1'b1;
    tick(4 * DIV + HALF);
    #2 rst = 1'b1;
    tick(2);
    rst = 1'b0;
    m_data = 8'h00;
    m_valid = 1'b0;
    chk("midrst_data", rx_data, 8'h00);
    chk("midrst_valid", rx_valid, 1'b0);
    tick(5 * DIV);
    chk("midrst_busy", rx_busy, 1'b0);
    frame_and_check("post_rst_5a", 8'h5A, 1'b1);

    // Ack coincident with the stop-bit sample of 0x77.
    o0 = ovr_seen;
    fork
      send_frame(8'h77, 1'b1);
      begin
        tick(2 + HALF + 9 * DIV);
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
      end
    join
    tick(4);
    m_data = 8'h77;
    m_valid = 1'b1;
    chk("ackcoin_valid", rx_valid, 1'b1);
    chk("ackcoin_data", rx_data, 8'h77);
    chk("ackcoin_ovr", ovr_seen - o0, 0);

    // Random frames against the model.
    for (int n = 0; n < 24; n++) begin
      frame_and_check("rand", 8'($urandom), ($urandom_range(0, 4) != 0));
      if ($urandom_range(0, 1) == 1) ack_pulse("rand_ack");
      tick($urandom_range(0, DIV));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_uart_rx
`default_nettype wire
